// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bundle: NREQ requesters offer (addr, data) under valid/ready.
// The master side is the requesters; the slave side is the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 5
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*ADDR_W-1:0] req_wa;
  logic [NREQ*DATA_W-1:0] req_wd;

  modport master (
    output req_valid,
    output req_wa,
    output req_wd,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_wa,
    input  req_wd,
    output req_ready
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates NREQ writeback requesters onto the single regfile write port.
// WB_ARB_RR_EN selects round-robin; default build is fixed priority (index 0 highest).
module regfile_wb_arbiter #(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  regfile_wb_arbiter_if.slave      bus,
  output logic                     o_rf_we,
  output logic [ADDR_W-1:0]        o_rf_wa,
  output logic [DATA_W-1:0]        o_rf_wd,
  output logic [$clog2(NREQ)-1:0]  o_grant_id,
  output logic [CNT_W-1:0]         o_conflict_cnt
);

  localparam int unsigned ID_W = $clog2(NREQ);

  logic              r_rf_we;
  logic [ADDR_W-1:0] r_rf_wa;
  logic [DATA_W-1:0] r_rf_wd;
  logic [ID_W-1:0]   r_grant_id;
  logic [CNT_W-1:0]  r_conflict_cnt;

  logic [NREQ-1:0]   w_ready;
  logic [ID_W-1:0]   w_gnt_idx;
  logic [ID_W-1:0]   w_cand;
  logic              w_gnt_any;
  logic              w_xfer;
  logic              w_conflict;
  logic [ADDR_W-1:0] w_wa;
  logic [DATA_W-1:0] w_wd;

`ifdef WB_ARB_RR_EN
  logic [ID_W-1:0]   r_rr_ptr;
`endif

  // First valid requester found, searching from the current highest-priority index.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
`ifdef WB_ARB_RR_EN
      w_cand = ID_W'((k + 32'(r_rr_ptr)) % NREQ);
`else
      w_cand = ID_W'(k);
`endif
      if (!w_gnt_any && bus.req_valid[w_cand]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  // Reset gates ready so nothing is consumed while the block is held.
  assign w_xfer = w_gnt_any & ~i_rst;

  always_comb begin
    w_ready = '0;
    if (w_xfer) begin
      w_ready[w_gnt_idx] = 1'b1;
    end
  end

  assign bus.req_ready = w_ready;
  assign w_wa          = bus.req_wa[32'(w_gnt_idx) * ADDR_W +: ADDR_W];
  assign w_wd          = bus.req_wd[32'(w_gnt_idx) * DATA_W +: DATA_W];
  assign w_conflict    = ($countones(bus.req_valid) >= 2);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rf_we        <= 1'b0;
      r_rf_wa        <= '0;
      r_rf_wd        <= '0;
      r_grant_id     <= '0;
      r_conflict_cnt <= '0;
    end else begin
      r_rf_we <= 1'b0;
      if (w_xfer) begin
        // x0 writes complete the handshake but never assert the regfile enable.
        r_rf_we    <= (w_wa != '0);
        r_rf_wa    <= w_wa;
        r_rf_wd    <= w_wd;
        r_grant_id <= w_gnt_idx;
      end
      if (w_conflict && (r_conflict_cnt != '1)) begin
        r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
      end
    end
  end

`ifdef WB_ARB_RR_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rr_ptr <= '0;
    end else if (w_xfer) begin
      r_rr_ptr <= (32'(w_gnt_idx) == NREQ - 1) ? '0 : w_gnt_idx + ID_W'(1);
    end
  end
`endif

  assign o_rf_we        = r_rf_we;
  assign o_rf_wa        = r_rf_wa;
  assign o_rf_wd        = r_rf_wd;
  assign o_grant_id     = r_grant_id;
  assign o_conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a grant model pushes expected writes to a
// scoreboard at handshake time; they are popped and compared after the next edge.
module tb_regfile_wb_arbiter;

  logic clk;
  logic rst;

  regfile_wb_arbiter_if #(.NREQ(2), .DATA_W(64), .ADDR_W(5)) bus_a ();
  regfile_wb_arbiter_if #(.NREQ(2), .DATA_W(64), .ADDR_W(5)) bus_b ();

  logic        rf_we,  rf_we_b;
  logic [4:0]  rf_wa,  rf_wa_b;
  logic [63:0] rf_wd,  rf_wd_b;
  logic        gid,    gid_b;
  logic [15:0] cnt;
  logic [1:0]  cnt_b;

  regfile_wb_arbiter #(.NREQ(2), .DATA_W(64), .ADDR_W(5), .CNT_W(16)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .bus            (bus_a),
    .o_rf_we        (rf_we),
    .o_rf_wa        (rf_wa),
    .o_rf_wd        (rf_wd),
    .o_grant_id     (gid),
    .o_conflict_cnt (cnt)
  );

  // Narrow counter instance for the saturation check.
  regfile_wb_arbiter #(.NREQ(2), .DATA_W(64), .ADDR_W(5), .CNT_W(2)) dut_sat (
    .i_clk          (clk),
    .i_rst          (rst),
    .bus            (bus_b),
    .o_rf_we        (rf_we_b),
    .o_rf_wa        (rf_wa_b),
    .o_rf_wd        (rf_wd_b),
    .o_grant_id     (gid_b),
    .o_conflict_cnt (cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Regfile stand-in fed by the main instance's write port.
  logic [63:0] tb_rf [32];
  always_ff @(posedge clk) begin
    if (rf_we) tb_rf[rf_wa] <= rf_wd;
  end

  typedef struct packed {
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic        id;
  } wr_t;

  wr_t sb[$];
  int  checks   = 0;
  int  failures = 0;
  int  m_ptr    = 0;
  int  m_cnt    = 0;
  int  m_cnt_b  = 0;
  logic [4:0]  m_wa = '0;
  logic [63:0] m_wd = '0;
  logic        m_id = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int model_grant(input logic [1:0] v);
`ifdef WB_ARB_RR_EN
    for (int k = 0; k < 2; k++) begin
      int idx;
      idx = (m_ptr + k) % 2;
      if (v[idx]) return idx;
    end
`else
    for (int k = 0; k < 2; k++) begin
      if (v[k]) return k;
    end
`endif
    return -1;
  endfunction

  task automatic drive(input logic [1:0] v, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [63:0] d0, input logic [63:0] d1);
    bus_a.req_valid = v;
    bus_a.req_wa    = {a1, a0};
    bus_a.req_wd    = {d1, d0};
    bus_b.req_valid = v;
    bus_b.req_wa    = {a1, a0};
    bus_b.req_wd    = {d1, d0};
  endtask

  // One cycle: drive, check handshake mid-cycle, check registered result after the edge.
  task automatic step(input string tag, input logic [1:0] v, input logic [4:0] a0,
                      input logic [4:0] a1, input logic [63:0] d0, input logic [63:0] d1);
    int   g;
    wr_t  e;
    logic [1:0] exp_rdy;
    drive(v, a0, a1, d0, d1);
    @(negedge clk);
    g       = model_grant(v);
    exp_rdy = (g >= 0) ? 2'(1 << g) : 2'b00;
    chk({tag, ".ready"}, 64'(bus_a.req_ready), 64'(exp_rdy));
    chk({tag, ".ready_b"}, 64'(bus_b.req_ready), 64'(exp_rdy));
    if (g >= 0) begin
      e.we = ((g == 0) ? a0 : a1) != 5'd0;
      e.wa = (g == 0) ? a0 : a1;
      e.wd = (g == 0) ? d0 : d1;
      e.id = 1'(g);
      sb.push_back(e);
      m_ptr = (g + 1) % 2;
    end
    if (v == 2'b11) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt_b < 3) m_cnt_b++;
    end
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e    = sb.pop_front();
      m_wa = e.wa;
      m_wd = e.wd;
      m_id = e.id;
      chk({tag, ".rf_we"}, 64'(rf_we), 64'(e.we));
    end else begin
      chk({tag, ".rf_we_idle"}, 64'(rf_we), 64'd0);
    end
    chk({tag, ".rf_wa"}, 64'(rf_wa), 64'(m_wa));
    chk({tag, ".rf_wd"}, rf_wd, m_wd);
    chk({tag, ".grant_id"}, 64'(gid), 64'(m_id));
    chk({tag, ".cnt"}, 64'(cnt), 64'(m_cnt));
    chk({tag, ".cnt_sat"}, 64'(cnt_b), 64'(m_cnt_b));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".ready"}, 64'(bus_a.req_ready), 64'd0);
    chk({tag, ".rf_we"}, 64'(rf_we), 64'd0);
    chk({tag, ".rf_wa"}, 64'(rf_wa), 64'd0);
    chk({tag, ".rf_wd"}, rf_wd, 64'd0);
    chk({tag, ".grant_id"}, 64'(gid), 64'd0);
    chk({tag, ".cnt"}, 64'(cnt), 64'd0);
    chk({tag, ".cnt_sat"}, 64'(cnt_b), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    drive(2'b00, 5'd0, 5'd0, 64'd0, 64'd0);
    #3;
    chk_reset_state("por");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single requester 1.
    step("solo1", 2'b10, 5'd0, 5'd7, 64'd0, 64'hDEAD_BEEF);
    // x0 write from requester 0: handshake completes, no enable.
    step("x0", 2'b01, 5'd0, 5'd0, 64'd5, 64'd0);
    step("idle0", 2'b00, 5'd0, 5'd0, 64'd0, 64'd0);

    // Contention for four cycles.
    for (int i = 0; i < 4; i++) begin
      step("both", 2'b11, 5'd3, 5'd4, 64'h30, 64'h40);
    end
    step("idle1", 2'b00, 5'd0, 5'd0, 64'd0, 64'd0);

    // Same destination from both: the later grant must land last.
    step("same_a", 2'b11, 5'd9, 5'd9, 64'd1, 64'd2);
    step("same_b", 2'b10, 5'd9, 5'd9, 64'd1, 64'd2);
    step("idle2", 2'b00, 5'd0, 5'd0, 64'd0, 64'd0);
    chk("rf_x9", tb_rf[9], 64'd2);

    // Long contention to saturate the narrow counter.
    for (int i = 0; i < 6; i++) begin
      step("sat", 2'b11, 5'd10, 5'd11, 64'hA, 64'hB);
    end

    // Mid-stream reset with both requesters still valid.
    #2;
    rst = 1'b1;
    #1;
    chk_reset_state("mid_rst");
    @(posedge clk);
    #1;
    chk_reset_state("mid_rst_edge");
    rst     = 1'b0;
    m_ptr   = 0;
    m_cnt   = 0;
    m_cnt_b = 0;
    m_wa    = '0;
    m_wd    = '0;
    m_id    = 1'b0;
    sb.delete();
    step("post_rst", 2'b11, 5'd12, 5'd13, 64'hC, 64'hD);
    step("post_rst2", 2'b11, 5'd12, 5'd13, 64'hC, 64'hD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case something wedges the sequence.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
